// File: rtl/sntrup_pkg.sv
// Shared constants and FSM state encoding for the SNTRUP757 coefficient readers.
package sntrup_pkg;

    localparam int unsigned P_SNTRUP = 757;
    localparam int unsigned IDX_W    = 11;
    localparam int unsigned DATA_W   = 26;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/mvu_stream_reader_stream_out_reg.sv
// Valid/ready output register: a held beat is never overwritten until it is accepted.
module stream_out_reg #(
    parameter int unsigned IDX_W  = sntrup_pkg::IDX_W,
    parameter int unsigned DATA_W = sntrup_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              ready_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [IDX_W-1:0]  index_i,
    input  logic              last_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [IDX_W-1:0]  index_o,
    output logic              last_o,
    output logic              ld_c_o
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic [IDX_W-1:0]  index_q, index_d;
    logic              last_q,  last_d;
    logic              ld_c;

    assign ld_c = !valid_q || ready_i;

    // Load a new beat when the slot is free or being emptied; otherwise retire an accepted beat.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        index_d = index_q;
        last_d  = last_q;
        if (load_i && ld_c) begin
            valid_d = 1'b1;
            data_d  = data_i;
            index_d = index_i;
            last_d  = last_i;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            index_q <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            index_q <= index_d;
            last_q  <= last_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign index_o = index_q;
    assign last_o  = last_q;
    assign ld_c_o  = ld_c;

endmodule

// File: rtl/mvu_stream_reader.sv
// Walks a combinational coefficient ROM over indices 0..P-1 and streams the
// registered coefficients out with valid/ready, last and a completion pulse.
module mvu_stream_reader #(
    parameter int unsigned P      = sntrup_pkg::P_SNTRUP,
    parameter int unsigned IDX_W  = sntrup_pkg::IDX_W,
    parameter int unsigned DATA_W = sntrup_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [IDX_W-1:0]  rom_index,
    input  logic [DATA_W-1:0] rom_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [IDX_W-1:0]  out_index,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    import sntrup_pkg::*;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(P - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q,   idx_d;
    logic             done_q,  done_d;
    logic             busy_q;
    logic             load_c;
    logic             ld_c;

    // Next-state: the index only advances when the output slot takes the current coefficient.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        load_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                load_c = 1'b1;
                if (ld_c) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DRAIN;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (out_valid && out_ready) begin
                    done_d  = 1'b1;
                    idx_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    stream_out_reg #(
        .IDX_W  (IDX_W),
        .DATA_W (DATA_W)
    ) u_out (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (load_c),
        .ready_i (out_ready),
        .data_i  (rom_data),
        .index_i (idx_q),
        .last_i  (idx_q == LAST_IDX),
        .valid_o (out_valid),
        .data_o  (out_data),
        .index_o (out_index),
        .last_o  (out_last),
        .ld_c_o  (ld_c)
    );

    assign rom_index = idx_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_mvu_stream_reader.sv
// Scoreboard bench: three readers (P=757, P=4, P=1) with directed stimulus and queue-based beat checking.
module tb_mvu_stream_reader;

    typedef struct packed {
        logic [25:0] data;
        logic [10:0] idx;
        logic        last;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic        rst_a = 1'b0, start_a = 1'b0, r_a = 1'b0;
    logic        rst_b = 1'b0, start_b = 1'b0, r_b = 1'b0;
    logic        rst_c = 1'b0, start_c = 1'b0, r_c = 1'b0;
    logic [10:0] ri_a, ri_b, ri_c, x_a, x_b, x_c;
    logic [25:0] rd_a, rd_b, rd_c, d_a, d_b, d_c;
    logic        v_a, v_b, v_c, l_a, l_b, l_c, b_a, b_b, b_c, dn_a, dn_b, dn_c;

    assign rd_a = (ri_a == 11'd0) ? 26'd1 : 26'd0;
    assign rd_b = 26'(ri_b) + 26'd100;
    assign rd_c = (ri_c == 11'd0) ? 26'd1 : 26'd0;

    mvu_stream_reader #(.P(757)) u_a (
        .clk(clk), .rst_n(rst_a), .start(start_a), .rom_index(ri_a), .rom_data(rd_a),
        .out_valid(v_a), .out_ready(r_a), .out_data(d_a), .out_index(x_a),
        .out_last(l_a), .busy(b_a), .done(dn_a));

    mvu_stream_reader #(.P(4)) u_b (
        .clk(clk), .rst_n(rst_b), .start(start_b), .rom_index(ri_b), .rom_data(rd_b),
        .out_valid(v_b), .out_ready(r_b), .out_data(d_b), .out_index(x_b),
        .out_last(l_b), .busy(b_b), .done(dn_b));

    mvu_stream_reader #(.P(1)) u_c (
        .clk(clk), .rst_n(rst_c), .start(start_c), .rom_index(ri_c), .rom_data(rd_c),
        .out_valid(v_c), .out_ready(r_c), .out_data(d_c), .out_index(x_c),
        .out_last(l_c), .busy(b_c), .done(dn_c));

    beat_t qa[$];
    beat_t qb[$];
    beat_t qc[$];
    int dcnt_a = 0, dcnt_b = 0, dcnt_c = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s", name);
    endtask

    function automatic beat_t mk(input int d, input int i, input bit l);
        beat_t b;
        b.data = 26'(d);
        b.idx  = 11'(i);
        b.last = l;
        return b;
    endfunction

    // Monitors: every presented beat (including stalled ones) must equal the head of its queue.
    always @(negedge clk) begin
        if (dn_a) dcnt_a++;
        if (v_a) begin
            if (qa.size() == 0) begin
                if (r_a) fail("a_unexpected_beat");
            end else begin
                chk("a_beat", 64'({d_a, x_a, l_a}), 64'(qa[0]));
                if (r_a) void'(qa.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (dn_b) dcnt_b++;
        if (v_b) begin
            if (qb.size() == 0) begin
                if (r_b) fail("b_unexpected_beat");
            end else begin
                chk("b_beat", 64'({d_b, x_b, l_b}), 64'(qb[0]));
                if (r_b) void'(qb.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (dn_c) dcnt_c++;
        if (v_c) begin
            if (qc.size() == 0) begin
                if (r_c) fail("c_unexpected_beat");
            end else begin
                chk("c_beat", 64'({d_c, x_c, l_c}), 64'(qc[0]));
                if (r_c) void'(qc.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_mvu_a();
        for (int i = 0; i < 757; i++) qa.push_back(mk((i == 0) ? 1 : 0, i, i == 756));
    endtask

    task automatic wait_done_a(input int max, output int cyc);
        cyc = 0;
        while (!dn_a && cyc < max) begin
            tick();
            cyc++;
        end
        if (!dn_a) fail("a_done_timeout");
    endtask

    task automatic wait_index_a(input int target);
        int n;
        n = 0;
        while (int'(x_a) != target && n < 1000) begin
            tick();
            n++;
        end
        if (int'(x_a) != target) fail("a_index_timeout");
    endtask

    task automatic pulse_start_a();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;

        // Reset values
        #2;
        chk("rst_a_valid", 64'(v_a), 64'd0);
        chk("rst_a_busy",  64'(b_a), 64'd0);
        chk("rst_a_done",  64'(dn_a), 64'd0);
        chk("rst_a_rom_index", 64'(ri_a), 64'd0);
        chk("rst_a_payload", 64'({d_a, x_a, l_a}), 64'd0);
        chk("rst_bc_valid", 64'({v_b, v_c, b_b, b_c}), 64'd0);
        tick();
        rst_a = 1'b1;
        rst_b = 1'b1;
        rst_c = 1'b1;
        tick();

        // Basic pass, P=757, ready held high
        r_a = 1'b1;
        push_mvu_a();
        pulse_start_a();
        chk("a_lat_valid_edge0", 64'(v_a), 64'd0);
        chk("a_lat_busy_edge0",  64'(b_a), 64'd1);
        tick();
        chk("a_first_valid", 64'(v_a), 64'd1);
        chk("a_first_beat", 64'({d_a, x_a}), 64'({26'd1, 11'd0}));
        chk("a_rom_index_adv", 64'(ri_a), 64'd1);
        wait_done_a(2000, cyc);
        chk("a_done_latency", 64'(cyc), 64'd757);
        chk("a_queue_empty", 64'(qa.size()), 64'd0);
        tick();
        chk("a_done_one_cycle", 64'(dn_a), 64'd0);
        chk("a_busy_after", 64'(b_a), 64'd0);
        chk("a_valid_after", 64'(v_a), 64'd0);
        chk("a_done_count1", 64'(dcnt_a), 64'd1);

        // Back-to-back pass with an ignored start at index 300
        push_mvu_a();
        pulse_start_a();
        tick();
        chk("a2_first_beat", 64'({v_a, d_a, x_a}), 64'({1'b1, 26'd1, 11'd0}));
        wait_index_a(300);
        pulse_start_a();
        wait_done_a(2000, cyc);
        chk("a2_queue_empty", 64'(qa.size()), 64'd0);
        for (int i = 0; i < 5; i++) tick();
        chk("a2_done_count", 64'(dcnt_a), 64'd2);
        chk("a2_idle", 64'({v_a, b_a}), 64'd0);

        // Reset mid-pass at index 200
        push_mvu_a();
        pulse_start_a();
        wait_index_a(200);
        #1;
        rst_a = 1'b0;
        #1;
        chk("a_rst_mid_valid", 64'(v_a), 64'd0);
        chk("a_rst_mid_busy",  64'(b_a), 64'd0);
        chk("a_rst_mid_done",  64'(dn_a), 64'd0);
        qa.delete();
        tick();
        rst_a = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("a_rst_no_restart", 64'({v_a, b_a}), 64'd0);
        push_mvu_a();
        pulse_start_a();
        tick();
        chk("a3_first_beat", 64'({v_a, d_a, x_a}), 64'({1'b1, 26'd1, 11'd0}));
        wait_done_a(2000, cyc);
        chk("a3_done_latency", 64'(cyc), 64'd757);
        tick();
        chk("a3_done_count", 64'(dcnt_a), 64'd3);

        // Backpressure, P=4, ready low for three cycles
        for (int i = 0; i < 4; i++) qb.push_back(mk(100 + i, i, i == 3));
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        begin
            int c;
            for (c = 1; c <= 15; c++) begin
                r_b = !(c >= 3 && c <= 5);
                tick();
                if (dn_b) break;
            end
            chk("b_done_edge", 64'(c), 64'd8);
        end
        chk("b_queue_empty", 64'(qb.size()), 64'd0);
        tick();
        chk("b_done_count", 64'(dcnt_b), 64'd1);
        chk("b_idle", 64'({v_b, b_b, dn_b}), 64'd0);

        // P=1: single beat, start on the completing edge is ignored
        r_c = 1'b1;
        qc.push_back(mk(1, 0, 1'b1));
        start_c = 1'b1;
        tick();
        start_c = 1'b0;
        tick();
        chk("c_beat_flags", 64'({v_c, l_c, b_c, x_c}), 64'({1'b1, 1'b1, 1'b1, 11'd0}));
        start_c = 1'b1;
        tick();
        start_c = 1'b0;
        chk("c_done", 64'({dn_c, b_c}), 64'({1'b1, 1'b0}));
        tick();
        chk("c_start_ignored", 64'({v_c, b_c, dn_c}), 64'd0);
        for (int i = 0; i < 4; i++) tick();
        chk("c_done_count", 64'(dcnt_c), 64'd1);
        chk("c_queue_empty", 64'(qc.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
